// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding bus access per core request, with byte-lane steering,
// load sign/zero extension and a WAIT watchdog. mem_fmt = {is_signed, width[1:0]}, width NONE=0 BYTE=1 HALF=2 WORD=3.
module lsu_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  off,
  input  logic [1:0]  width,
  input  logic [31:0] wdata,
  output logic        be,
  output logic [7:0]  wbyte
);
  localparam logic [2:0] L = 3'(LANE);

  always_comb begin
    be    = 1'b0;
    wbyte = 8'h00;
    unique case (width)
      2'd1: begin
        be    = ({1'b0, off} == L);
        wbyte = wdata[7:0];
      end
      2'd2: begin
        be    = (L >= {1'b0, off}) && (L <= {1'b0, off} + 3'd1);
        wbyte = wdata[8*(LANE%2) +: 8];
      end
      2'd3: begin
        be    = 1'b1;
        wbyte = wdata[8*LANE +: 8];
      end
      default: ;
    endcase
  end
endmodule

module load_store_unit #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_fmt,
  output logic [31:0] mem_rdata,
  output logic        lsu_stall,
  output logic        lsu_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);
  localparam int CW = $clog2(BUS_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  state_t state, state_nxt;

  logic [31:0]   addr_q, wdata_q, rdata_q, ld_data, ld_sh;
  logic [2:0]    fmt_q;
  logic          we_q;
  logic [CW-1:0] cnt;
  logic          access, aligned, legal, timeout;

  always_comb begin
    access  = (mem_re | mem_we) && (mem_fmt[1:0] != 2'd0);
    aligned = (mem_fmt[1:0] == 2'd2) ? !mem_addr[0] :
              (mem_fmt[1:0] == 2'd3) ? (mem_addr[1:0] == 2'b00) : 1'b1;
    legal   = access && (mem_re ^ mem_we) && aligned;
    timeout = (cnt == CW'(BUS_TIMEOUT - 1));
  end

  // Load extraction uses the latched offset/format, never the live core inputs.
  always_comb begin
    ld_sh = bus_rdata >> {addr_q[1:0], 3'b000};
    unique case (fmt_q[1:0])
      2'd1:    ld_data = {{24{fmt_q[2] & ld_sh[7]}}, ld_sh[7:0]};
      2'd2:    ld_data = {{16{fmt_q[2] & ld_sh[15]}}, ld_sh[15:0]};
      default: ld_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (legal) state_nxt = S_REQ;
      S_REQ:  if (bus_gnt) state_nxt = we_q ? S_DONE : S_WAIT;
      S_WAIT: if (bus_rvalid || timeout) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    lsu_stall = 1'b0;
    lsu_err   = 1'b0;
    bus_req   = 1'b0;
    mem_rdata = 32'h0;
    if (!rst) begin
      unique case (state)
        S_IDLE: begin
          lsu_stall = legal;
          lsu_err   = access && !legal;
        end
        S_REQ: begin
          lsu_stall = 1'b1;
          bus_req   = 1'b1;
        end
        S_WAIT: begin
          lsu_stall = 1'b1;
          lsu_err   = !bus_rvalid && timeout;
        end
        S_DONE: mem_rdata = rdata_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      fmt_q   <= 3'h0;
      we_q    <= 1'b0;
      rdata_q <= 32'h0;
      cnt     <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (legal) begin
          addr_q  <= mem_addr;
          wdata_q <= mem_wdata;
          fmt_q   <= mem_fmt;
          we_q    <= mem_we;
          rdata_q <= 32'h0;
          cnt     <= '0;
        end
        S_WAIT: begin
          if (bus_rvalid)   rdata_q <= ld_data;
          else if (timeout) rdata_q <= 32'h0;
          else              cnt     <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus_we   = we_q;
  assign bus_addr = {addr_q[31:2], 2'b00};

  for (genvar i = 0; i < 4; i++) begin : g_lane
    lsu_lane #(.LANE(i)) u_lane (
      .off   (addr_q[1:0]),
      .width (fmt_q[1:0]),
      .wdata (wdata_q),
      .be    (bus_be[i]),
      .wbyte (bus_wdata[8*i +: 8])
    );
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Random and directed load/store traffic against a byte-level reference model of lane steering and extension.
module tb_load_store_unit;
  localparam int TO = 255;

  logic        clk = 1'b0, rst;
  logic        mem_re, mem_we, lsu_stall, lsu_err, bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, bus_addr, bus_wdata, bus_rdata;
  logic [2:0]  mem_fmt;
  logic [3:0]  bus_be;
  int errs = 0, checks = 0;

  load_store_unit #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_fmt(mem_fmt), .mem_rdata(mem_rdata), .lsu_stall(lsu_stall),
    .lsu_err(lsu_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int fsize(input logic [1:0] w);
    return (w == 2'd1) ? 1 : (w == 2'd2) ? 2 : (w == 2'd3) ? 4 : 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] f);
    logic [3:0] r = 4'b0;
    int off = int'(a[1:0]), sz = fsize(f[1:0]);
    for (int i = 0; i < 4; i++) if (i >= off && i < off + sz) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] m_wd(input logic [31:0] d, input logic [2:0] f);
    logic [31:0] r = 32'h0;
    int sz = fsize(f[1:0]);
    for (int i = 0; i < 4; i++) r = r | (((d >> (8 * (i % sz))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] m_ld(input logic [31:0] d, input logic [31:0] a, input logic [2:0] f);
    int sz = fsize(f[1:0]);
    longint span = longint'(1) << (8 * sz);
    longint v = longint'(d >> (8 * int'(a[1:0]))) % span;
    if (f[2] && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // rd < 0 means the bus never returns data.
  task automatic run(input logic re, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] f, input int gd, input int rd, input logic [31:0] rdat);
    int sz = fsize(f[1:0]);
    bit acc = (re || we) && sz != 0;
    bit leg = acc && (re != we) && (a % sz == 0);
    int n;
    mem_re = re; mem_we = we; mem_addr = a; mem_wdata = wd; mem_fmt = f;
    @(negedge clk);
    if (!leg) begin
      chk("ill_err", lsu_err, acc);
      chk("ill_stall", lsu_stall, 0);
      chk("ill_req", bus_req, 0);
      chk("ill_rdata", mem_rdata, 0);
      @(posedge clk); #1;
      mem_re = 0; mem_we = 0;
      @(negedge clk);
      chk("ill_idle_req", bus_req, 0);
      chk("ill_idle_err", lsu_err, 0);
      @(posedge clk); #1;
      return;
    end
    chk("idle_stall", lsu_stall, 1);
    chk("idle_req", bus_req, 0);
    chk("idle_err", lsu_err, 0);
    @(posedge clk); #1;
    mem_addr = $urandom; mem_wdata = $urandom; mem_fmt = 3'($urandom);
    for (int g = 0; g <= gd; g++) begin
      bus_rvalid = 1'($urandom); bus_rdata = $urandom;
      @(negedge clk);
      chk("req_req", bus_req, 1);
      chk("req_stall", lsu_stall, 1);
      chk("req_addr", bus_addr, a & 32'hFFFF_FFFC);
      chk("req_be", bus_be, m_be(a, f));
      chk("req_we", bus_we, we);
      if (we) chk("req_wdata", bus_wdata, m_wd(wd, f));
      chk("req_rdata", mem_rdata, 0);
      if (g == gd) bus_gnt = 1;
      @(posedge clk); #1;
      bus_gnt = 0;
    end
    bus_rvalid = 0;
    if (re) begin
      n = (rd < 0) ? TO : rd + 1;
      for (int w = 0; w < n; w++) begin
        bus_gnt = 1'($urandom); bus_rdata = $urandom;
        @(negedge clk);
        chk("wait_stall", lsu_stall, 1);
        chk("wait_req", bus_req, 0);
        chk("wait_rdata", mem_rdata, 0);
        chk("wait_err", lsu_err, (rd < 0 && w == n - 1));
        if (rd >= 0 && w == rd) begin bus_rvalid = 1; bus_rdata = rdat; end
        @(posedge clk); #1;
        bus_rvalid = 0;
      end
    end
    mem_re = 0; mem_we = 0;
    bus_rvalid = 1'($urandom); bus_gnt = 1'($urandom); bus_rdata = $urandom;
    @(negedge clk);
    chk("done_stall", lsu_stall, 0);
    chk("done_req", bus_req, 0);
    chk("done_err", lsu_err, 0);
    chk("done_rdata", mem_rdata, (re && rd >= 0) ? m_ld(rdat, a, f) : 32'h0);
    @(posedge clk); #1;
    bus_rvalid = 0; bus_gnt = 0;
  endtask

  initial begin
    rst = 1; mem_re = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; mem_fmt = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", lsu_stall, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_err", lsu_err, 0);
    chk("rst_rdata", mem_rdata, 0);
    @(posedge clk); #1;
    rst = 0;

    run(1, 0, 32'h103, 32'h0, 3'b101, 0, 0, 32'h80FF_FF7F);      // LB signed
    run(0, 1, 32'h202, 32'h1234_ABCD, 3'b010, 0, 0, 32'h0);       // SH
    run(1, 0, 32'h101, 32'h0, 3'b011, 0, 0, 32'h0);               // misaligned LW
    run(1, 0, 32'h40, 32'h0, 3'b000, 0, 0, 32'h0);                // width NONE
    run(1, 1, 32'h40, 32'h5, 3'b011, 0, 0, 32'h0);                // both re and we
    run(0, 1, 32'h3C, 32'hCAFE_F00D, 3'b011, 5, 0, 32'h0);        // backpressure
    run(1, 0, 32'h82, 32'h0, 3'b110, 5, 2, 32'h8001_7FFF);        // LH signed, slow
    run(1, 0, 32'h80, 32'h0, 3'b011, 0, -1, 32'h0);               // timeout
    run(1, 0, 32'h81, 32'h0, 3'b001, 0, 0, 32'hDEAD_BEEF);        // LBU after timeout

    // Reset while waiting for read data, then a stray rvalid.
    mem_re = 1; mem_we = 0; mem_addr = 32'h44; mem_fmt = 3'b011;
    @(negedge clk); bus_gnt = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_stall_pre", lsu_stall, 1);
    @(posedge clk); #1;
    bus_gnt = 0;
    @(negedge clk);
    rst = 1; mem_re = 0;
    #1;
    chk("rw_stall", lsu_stall, 0);
    chk("rw_req", bus_req, 0);
    chk("rw_err", lsu_err, 0);
    @(posedge clk); #1;
    rst = 0; bus_rvalid = 1; bus_rdata = 32'h1357_9BDF;
    @(negedge clk);
    chk("rw_late_stall", lsu_stall, 0);
    chk("rw_late_req", bus_req, 0);
    chk("rw_late_rdata", mem_rdata, 0);
    @(posedge clk); #1;
    bus_rvalid = 0;
    @(negedge clk);
    chk("rw_after_rdata", mem_rdata, 0);
    chk("rw_after_stall", lsu_stall, 0);
    @(posedge clk); #1;
    run(1, 0, 32'h46, 32'h0, 3'b010, 1, 1, 32'hF00F_8421);

    for (int k = 0; k < 80; k++)
      run(1'($urandom), 1'($urandom), (k % 3 == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom,
          $urandom, 3'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 255, meaning the maximum cycles in WAIT before the transaction is abandoned.
REQ-002 SHALL have port clk, input, 1: the only clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port mem_re, input, 1: core load request, from the EX/MEM register, held stable while lsu_stall=1.
REQ-005 SHALL have port mem_we, input, 1: core store request, held stable while lsu_stall=1.
REQ-006 SHALL have port mem_addr, input, 32: byte address.
REQ-007 SHALL have port mem_wdata, input, 32: store data, right-aligned.
REQ-008 SHALL have port mem_fmt, input, mem_fmt_t: width (NONE/BYTE/HALF/WORD) plus is_signed.
REQ-009 SHALL have port mem_rdata, output, 32: formatted load data returned to the core.
REQ-010 SHALL have port lsu_stall, output, 1: freeze the pipeline.
REQ-011 SHALL have port lsu_err, output, 1: one-cycle pulse on a misaligned, illegal or timed-out access.
REQ-012 SHALL have port bus_req, output, 1: bus request.
REQ-013 SHALL have port bus_we, output, 1: write strobe.
REQ-014 SHALL have port bus_addr, output, 32: word address, bits[1:0]=0.
REQ-015 SHALL have port bus_be, output, 4: byte enables.
REQ-016 SHALL have port bus_wdata, output, 32: lane-replicated store data.
REQ-017 SHALL have port bus_gnt, input, 1: request accepted.
REQ-018 SHALL have port bus_rvalid, input, 1: read data valid.
REQ-019 SHALL have port bus_rdata, input, 32: read word.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-021 An access SHALL be defined as (mem_re|mem_we) & width!=NONE, sampled in IDLE; width NONE SHALL cause no transaction, no stall and no error.
REQ-022 An access SHALL be legal when exactly one of re/we is set and it is aligned (HALF: addr[0]=0; WORD: addr[1:0]=0).
REQ-023 A legal access in IDLE SHALL assert lsu_stall combinationally in the same cycle and transition to REQ.
REQ-024 An illegal access in IDLE SHALL pulse lsu_err, drive mem_rdata=0, keep lsu_stall=0, issue no bus_req and stay in IDLE.
REQ-025 In REQ, bus_req SHALL be 1 and bus_addr/bus_we/bus_be/bus_wdata SHALL be stable until bus_gnt; the FSM SHALL go to DONE on gnt for a store and to WAIT on gnt for a load.
REQ-026 In WAIT, the FSM SHALL capture bus_rdata into rdata_q on bus_rvalid and go to DONE.
REQ-027 The FSM SHALL count WAIT cycles, and on reaching BUS_TIMEOUT SHALL pulse lsu_err, set rdata_q=0 and go to DONE.
REQ-028 lsu_stall SHALL be 1 in REQ and WAIT, and 0 in DONE.
REQ-029 DONE SHALL drive mem_rdata from rdata_q and return to IDLE unconditionally.
REQ-030 Minimum stall SHALL be 2 cycles for a store and 3 cycles for a load (gnt same cycle, rvalid next cycle).
REQ-031 bus_be SHALL be BYTE: 1<<addr[1:0]; HALF: 4'b0011<<addr[1:0]; WORD: 4'b1111; and 0 for loads' write path is don't-care, with loads driving bus_be from the same rule.
REQ-032 bus_wdata SHALL be BYTE: {4{wdata[7:0]}}; HALF: {2{wdata[15:0]}}; WORD: wdata.
REQ-033 Load data SHALL be the byte/half selected by registered addr[1:0], sign-extended when is_signed=1, else zero-extended; WORD SHALL pass through.
REQ-034 Address, fmt and wdata SHALL be latched on leaving IDLE; the core inputs are not used again until IDLE.
REQ-035 bus_rvalid outside WAIT and bus_gnt outside REQ SHALL be ignored.
REQ-036 mem_rdata SHALL be 0 in IDLE, REQ and WAIT.

Reset
REQ-037 rst SHALL force state IDLE, bus_req=0, lsu_stall=0, lsu_err=0, rdata_q=0, timeout count=0, asynchronously.
REQ-038 Reset during REQ/WAIT SHALL abandon the transaction; a later rvalid SHALL be ignored.

Verification
REQ-039 Load: LB at addr 0x103, bus_rdata 0x80FF_FF7F, gnt immediate, rvalid +1 -> bus_be=1000, mem_rdata=0xFFFF_FF80 in DONE, stall high 3 cycles.
REQ-040 Store: SH wdata 0x1234_ABCD at 0x202 -> bus_addr=0x200, bus_be=1100, bus_wdata=0xABCD_ABCD, bus_we=1.
REQ-041 Misaligned: LW at 0x101 -> lsu_err pulse, bus_req never set, lsu_stall 0.
REQ-042 Backpressure: bus_gnt low 5 cycles -> bus_req and all bus outputs stable, stall held.
REQ-043 Timeout: no rvalid for 255 cycles -> lsu_err pulse, mem_rdata=0, then IDLE.
REQ-044 Reset in WAIT, then rvalid -> IDLE, stall 0, no data or state change.
